// File: rtl/nfu_pkg.sv
// nfu_pkg: shared constants, coefficient-word layout and loader FSM
// encoding for the NFU-3 sigmoid coefficient-load path.
package nfu_pkg;

  // Fixed-point data width; one coefficient word carries {a, b}.
  localparam int N       = 16;
  // Number of piecewise sigmoid segments per coefficient load.
  localparam int NUM_SEG = 16;
  // Segment address width; NUM_SEG is always 2**ADDR_W.
  localparam int ADDR_W  = 4;

  // Field offsets inside a 2N-bit coefficient word.
  localparam int A_MSB = 2*N-1;
  localparam int A_LSB = N;
  localparam int B_MSB = N-1;
  localparam int B_LSB = 0;

  // Loader states. The encoding is fixed so a debug probe on the state
  // register reads the same values the lane firmware documentation uses.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // Build a coefficient word from its slope and offset halves.
  function automatic logic [2*N-1:0] pack_coef(input logic [N-1:0] a,
                                               input logic [N-1:0] b);
    logic [2*N-1:0] w;
    w = '0;
    w[A_MSB:A_LSB] = a;
    w[B_MSB:B_LSB] = b;
    return w;
  endfunction

endpackage

// File: rtl/nfu3_coef_loader_if.sv
// nfu3_coef_loader_if: valid/ready stream that carries packed {a, b}
// coefficient words from the buffer/DMA side into the loader.
// Signal names keep the loader's point of view (i_ = into the loader).
interface nfu3_coef_loader_if
  import nfu_pkg::*;
#(
  parameter int W = 2*N
) ();

  logic         i_coef_valid;
  logic [W-1:0] i_coef_data;
  logic         o_coef_ready;

  // Upstream producer: drives the word and its valid, watches ready.
  modport master (
    output i_coef_valid,
    output i_coef_data,
    input  o_coef_ready
  );

  // The loader: consumes the word and raises ready while loading.
  modport slave (
    input  i_coef_valid,
    input  i_coef_data,
    output o_coef_ready
  );

endinterface

// File: rtl/nfu3_coef_loader.sv
// nfu3_coef_loader: writer side of the NFU-3 sigmoid coefficient bus.
// Takes NUM_SEG coefficient words from a valid/ready stream and replays
// them, one registered cycle later, as address + data + write strobe to
// the coefficient RAMs of every sigmoid lane, then pulses o_done.
//
// Optional build macro NFU3_COEF_CKSUM_EN: each load takes one extra
// trailing word, a modular sum of the data words. It is compared against
// a running sum and the result is reported on o_cksum_err.
module nfu3_coef_loader
  import nfu_pkg::*;
#(
  parameter int N       = nfu_pkg::N,
  parameter int NUM_SEG = nfu_pkg::NUM_SEG,
  parameter int ADDR_W  = nfu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  nfu3_coef_loader_if.slave coef_if,
  input  logic              i_start,
  output logic [2*N-1:0]    o_coef,
  output logic [ADDR_W-1:0] o_coef_addr,
  output logic              o_load_coef,
  output logic              o_busy,
`ifdef NFU3_COEF_CKSUM_EN
  output logic              o_done,
  output logic              o_cksum_err
`else
  output logic              o_done
`endif
);

  localparam logic [ADDR_W-1:0] LAST_SEG = ADDR_W'(NUM_SEG-1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]    coef_q;
  logic [ADDR_W-1:0] addr_q;
  logic              load_q;

  logic              xfer;
  logic              data_xfer;
  logic              last_seg;

`ifdef NFU3_COEF_CKSUM_EN
  logic              ck_phase_q, ck_phase_d;
  logic [2*N-1:0]    sum_q;
  logic              err_q;
  logic              ck_xfer;
`endif

  // Ready depends only on state so upstream may wait for it before
  // raising valid without creating a combinational loop.
  assign coef_if.o_coef_ready = (state_q == LOAD);
  assign xfer                 = coef_if.i_coef_valid & coef_if.o_coef_ready;
  assign last_seg             = (cnt_q == LAST_SEG);

`ifdef NFU3_COEF_CKSUM_EN
  // Once all segments are taken, the counter has wrapped to 0 and the
  // phase flag marks the next accepted word as the checksum.
  assign data_xfer = xfer & ~ck_phase_q;
  assign ck_xfer   = xfer &  ck_phase_q;
`else
  assign data_xfer = xfer;
`endif

  // Next-state logic: start only counts in IDLE, the final accepted
  // word moves to DONE, and DONE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef NFU3_COEF_CKSUM_EN
    ck_phase_d = ck_phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef NFU3_COEF_CKSUM_EN
          ck_phase_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (data_xfer) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (last_seg) begin
`ifdef NFU3_COEF_CKSUM_EN
            ck_phase_d = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef NFU3_COEF_CKSUM_EN
        if (ck_xfer) begin
          state_d    = DONE;
          ck_phase_d = 1'b0;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and segment counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef NFU3_COEF_CKSUM_EN
  // Checksum phase flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_phase_q <= 1'b0;
    end else begin
      ck_phase_q <= ck_phase_d;
    end
  end
`endif

  // Registered write path: an accepted data word becomes a lane RAM
  // write one cycle later; data and address hold between strobes, and
  // reset also kills a strobe that was about to go out.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q <= '0;
      addr_q <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= data_xfer;
      if (data_xfer) begin
        coef_q <= coef_if.i_coef_data;
        addr_q <= cnt_q;
      end
    end
  end

`ifdef NFU3_COEF_CKSUM_EN
  // Running modular sum of the data words and the checksum verdict.
  // The verdict is captured as the checksum word is accepted so it is
  // already valid alongside o_done, and it stays until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && i_start) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (data_xfer) begin
      sum_q <= sum_q + coef_if.i_coef_data;
    end else if (ck_xfer) begin
      err_q <= (sum_q != coef_if.i_coef_data);
    end
  end

  assign o_cksum_err = err_q;
`endif

  assign o_coef      = coef_q;
  assign o_coef_addr = addr_q;
  assign o_load_coef = load_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_nfu3_coef_loader.sv
// tb_nfu3_coef_loader: self-checking bench for nfu3_coef_loader.
// A transaction-level reference model (word count, running sum) predicts
// every output each cycle; a vector table and directed load sequences
// cover the corner cases, followed by randomized traffic.
// Builds with or without NFU3_COEF_CKSUM_EN.
module tb_nfu3_coef_loader;
  import nfu_pkg::*;

  localparam int W = 2*N;
`ifdef NFU3_COEF_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [W-1:0]      o_coef;
  logic [ADDR_W-1:0] o_coef_addr;
  logic              o_load_coef;
  logic              o_busy;
  logic              o_done;
  logic              cksumErr;

  nfu3_coef_loader_if #(.W(W)) coef_if ();

  nfu3_coef_loader dut (
    .clk         (clk),
    .rst         (rst),
    .coef_if     (coef_if),
    .i_start     (i_start),
    .o_coef      (o_coef),
    .o_coef_addr (o_coef_addr),
    .o_load_coef (o_load_coef),
    .o_busy      (o_busy),
`ifdef NFU3_COEF_CKSUM_EN
    .o_done      (o_done),
    .o_cksum_err (cksumErr)
`else
    .o_done      (o_done)
`endif
  );

`ifndef NFU3_COEF_CKSUM_EN
  assign cksumErr = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 loading, 2 finished; words taken
  // so far in this load and their modular sum.
  int           mMode  = 0;
  int           mCount = 0;
  logic [W-1:0] mSum   = '0;
  logic         eLoad  = 1'b0;
  logic [W-1:0] eCoef  = '0;
  int           eAddr  = 0;
  logic         eErr   = 1'b0;

  int strobes = 0;
  int dones   = 0;

  typedef struct {
    bit           r;
    bit           s;
    bit           v;
    logic [W-1:0] d;
    bit           xReady;
    bit           xBusy;
    bit           xLoad;
    logic [W-1:0] xCoef;
    int           xAddr;
  } vec_t;

  vec_t vecs[9];

  task automatic cmp(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit s, input bit v,
                           input logic [W-1:0] d);
    if (r) begin
      mMode = 0; mCount = 0; mSum = '0;
      eLoad = 1'b0; eCoef = '0; eAddr = 0; eErr = 1'b0;
    end else begin
      eLoad = 1'b0;
      case (mMode)
        0: if (s) begin
          mMode = 1; mCount = 0; mSum = '0; eErr = 1'b0;
        end
        1: if (v) begin
          if (mCount < NUM_SEG) begin
            eLoad = 1'b1;
            eCoef = d;
            eAddr = mCount;
            mSum  = mSum + d;
            mCount++;
            if (mCount == NUM_SEG && !CK) mMode = 2;
          end else begin
            eErr  = (mSum != d);
            mMode = 2;
          end
        end
        default: mMode = 0;
      endcase
    end
  endtask

  task automatic checkOutput();
    cmp("ready", W'(coef_if.o_coef_ready), W'(mMode == 1));
    cmp("busy",  W'(o_busy),      W'(mMode != 0));
    cmp("done",  W'(o_done),      W'(mMode == 2));
    cmp("load",  W'(o_load_coef), W'(eLoad));
    cmp("coef",  o_coef,          eCoef);
    cmp("addr",  W'(o_coef_addr), W'(eAddr));
    if (CK) cmp("cksum_err", W'(cksumErr), W'(eErr));
    if (o_load_coef === 1'b1) strobes++;
    if (o_done === 1'b1) dones++;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input bit r, input bit s, input bit v,
                               input logic [W-1:0] d);
    rst                  = r;
    i_start              = s;
    coef_if.i_coef_valid = v;
    coef_if.i_coef_data  = d;
    modelStep(r, s, v, d);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // One complete load: start (valid already high in IDLE), NUM_SEG words
  // of base + k*step, optional checksum word offset by delta, then the
  // DONE cycle with a stray start. startAt re-pulses start mid-load.
  task automatic runLoad(input bit bubble, input logic [W-1:0] base,
                         input logic [W-1:0] step, input int startAt,
                         input logic [W-1:0] delta);
    logic [W-1:0] sum;
    int k;
    int cyc;
    sum = '0;
    strobes = 0;
    dones = 0;
    applyStimulus(0, 1, 1, 32'hDEAD_BEEF);
    k = 0;
    cyc = 0;
    while (k < NUM_SEG) begin
      bit v;
      v = bubble ? (cyc % 2 == 0) : 1'b1;
      applyStimulus(0, (k == startAt), v, base + W'(k) * step);
      if (v) begin
        sum = sum + base + W'(k) * step;
        k++;
      end
      cyc++;
    end
    if (CK) applyStimulus(0, 0, 1, sum + delta);
    applyStimulus(0, 1, 1, 32'hCAFE_F00D);
    cmp("strobe_count", W'(strobes), W'(NUM_SEG));
    cmp("done_count",   W'(dones),   W'(1));
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    coef_if.i_coef_valid = 1'b0;
    coef_if.i_coef_data = '0;

    vecs[0] = '{1, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0};
    vecs[1] = '{0, 0, 1, 32'hAAAA_AAAA, 0, 0, 0, 32'h0,         0};
    vecs[2] = '{0, 1, 0, 32'h0,         1, 1, 0, 32'h0,         0};
    vecs[3] = '{0, 0, 1, 32'h1111_2222, 1, 1, 1, 32'h1111_2222, 0};
    vecs[4] = '{0, 0, 0, 32'h9999_9999, 1, 1, 0, 32'h1111_2222, 0};
    vecs[5] = '{0, 1, 1, 32'h3333_4444, 1, 1, 1, 32'h3333_4444, 1};
    vecs[6] = '{0, 0, 1, 32'h5555_6666, 1, 1, 1, 32'h5555_6666, 2};
    vecs[7] = '{1, 1, 1, 32'h7777_8888, 0, 0, 0, 32'h0,         0};
    vecs[8] = '{0, 0, 1, 32'h7777_8888, 0, 0, 0, 32'h0,         0};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].d);
      cmp($sformatf("vec%0d_ready", i), W'(coef_if.o_coef_ready), W'(vecs[i].xReady));
      cmp($sformatf("vec%0d_busy", i),  W'(o_busy),      W'(vecs[i].xBusy));
      cmp($sformatf("vec%0d_load", i),  W'(o_load_coef), W'(vecs[i].xLoad));
      cmp($sformatf("vec%0d_coef", i),  o_coef,          vecs[i].xCoef);
      cmp($sformatf("vec%0d_addr", i),  W'(o_coef_addr), W'(vecs[i].xAddr));
    end

    $display("[TB] full load, valid held high");
    runLoad(0, 32'h0001_0000, 32'h1, -1, '0);
    applyStimulus(0, 0, 0, '0);

    $display("[TB] bubbled valid");
    runLoad(1, 32'h0002_0000, 32'h3, -1, '0);
    applyStimulus(0, 0, 1, 32'h1234_5678);

    $display("[TB] stray start mid-load and in DONE");
    runLoad(0, 32'h0003_0000, 32'h1, 5, '0);
    applyStimulus(0, 0, 0, '0);

    $display("[TB] reset mid-load");
    applyStimulus(0, 1, 0, '0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, 32'h0004_0000 + W'(k));
    cmp("pre_reset_addr", W'(o_coef_addr), W'(7));
    applyStimulus(1, 0, 1, 32'h0004_0008);
    cmp("post_reset_load", W'(o_load_coef), W'(0));
    cmp("post_reset_busy", W'(o_busy), W'(0));
    cmp("post_reset_addr", W'(o_coef_addr), W'(0));
    runLoad(0, 32'h0005_0000, 32'h1, -1, '0);

    $display("[TB] back-to-back loads");
    runLoad(0, 32'h0006_0000, 32'h1, -1, '0);

`ifdef NFU3_COEF_CKSUM_EN
    $display("[TB] checksum good and bad");
    applyStimulus(0, 0, 0, '0);
    runLoad(0, 32'h1, 32'h0, -1, '0);
    applyStimulus(0, 0, 0, '0);
    cmp("cksum_good", W'(cksumErr), W'(0));
    runLoad(0, 32'h1, 32'h0, -1, 32'h1);
    applyStimulus(0, 0, 0, '0);
    cmp("cksum_bad", W'(cksumErr), W'(1));
    applyStimulus(0, 0, 1, 32'h5);
    cmp("cksum_hold", W'(cksumErr), W'(1));
    applyStimulus(0, 1, 0, '0);
    cmp("cksum_clear", W'(cksumErr), W'(0));
`endif

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(($urandom % 300) == 0, ($urandom % 6) == 0,
                    ($urandom % 3) != 0, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
